axis_segmented_bram_writer: RTL

Upstream companion of the segmented BRAM reader. It takes an AXI4-Stream of samples and writes them into one BRAM segment, from a start offset up to an inclusive end address. When the segment is complete it raises a done handshake. The segment then holds exactly the words that the reader streams out for the same offset/end pair.

---
 rtl/axis_segmented_bram_pkg.sv | 16 +
 rtl/axis_segment_addr_cntr.sv | 48 ++++
 rtl/axis_segmented_bram_writer.sv | 117 +++++++++++
 3 files changed

// File: rtl/axis_segmented_bram_pkg.sv
// Shared types for the segmented BRAM writer/reader pair.
//   state_t   : segment FSM states
//   cnt_width : width of a word counter that must reach 2^A (A+1 bits)
package axis_segmented_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/axis_segment_addr_cntr.sv
// Segment address / word counter, shared by the segmented BRAM writer and reader.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   load             : latch offset into addr and end_addr into end_reg, clear count
//   offset, end_addr : segment bounds (end inclusive)
//   beat             : one word transferred this cycle, count increments
//   stop             : this beat is the final one, addr holds instead of incrementing
//   addr, count      : current address, words transferred so far
//   is_last          : addr has reached end_reg
module axis_segment_addr_cntr
    import axis_segmented_bram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic [ADDR_W-1:0]              offset,
    input  logic [ADDR_W-1:0]              end_addr,
    input  logic                           beat,
    input  logic                           stop,
    output logic [ADDR_W-1:0]              addr,
    output logic [cnt_width(ADDR_W)-1:0]   count,
    output logic                           is_last
);

    logic [ADDR_W-1:0] end_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr    <= '0;
            end_reg <= '0;
            count   <= '0;
        end else if (load) begin
            addr    <= offset;
            end_reg <= end_addr;
            count   <= '0;
        end else if (beat) begin
            count <= count + 1'b1;
            // Holding addr on the final beat means addr never wraps past 2^A-1.
            if (!stop)
                addr <= addr + 1'b1;
        end
    end

    assign is_last = (addr == end_reg);

endmodule

// File: rtl/axis_segmented_bram_writer.sv
// AXI4-Stream to BRAM segment writer. Writes samples from cfg_offset up to
// cfg_end (inclusive), then raises m_axis_done_tvalid until acknowledged.
// Optional feature macro: AXIS_SEGMENTED_BRAM_WRITER_TLAST_EN
//   defined   : an accepted beat with s_axis_tlast ends the segment early
//   undefined : s_axis_tlast is ignored
// Ports:
//   aclk, aresetn                 : clock, synchronous active-low reset
//   cfg_offset, cfg_end, start    : segment bounds, armed by start in IDLE
//   sts_data, sts_count           : current address, words written
//   s_axis_*                      : sample stream (tready high only in WRITE)
//   m_axis_done_tvalid/tready     : segment-complete handshake
//   bram_portb_*                  : BRAM write port, combinational from the handshake
module axis_segmented_bram_writer
    import axis_segmented_bram_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 10
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [BRAM_ADDR_WIDTH-1:0]    cfg_offset,
    input  logic [BRAM_ADDR_WIDTH-1:0]    cfg_end,
    input  logic                          start,
    output logic [BRAM_ADDR_WIDTH-1:0]    sts_data,
    output logic [BRAM_ADDR_WIDTH:0]      sts_count,
    output logic                          s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          m_axis_done_tvalid,
    input  logic                          m_axis_done_tready,
    output logic                          bram_portb_clk,
    output logic                          bram_portb_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]    bram_portb_addr,
    output logic [BRAM_DATA_WIDTH-1:0]    bram_portb_wrdata,
    output logic                          bram_portb_we
);

`ifdef AXIS_SEGMENTED_BRAM_WRITER_TLAST_EN
    localparam logic TLAST_EN = 1'b1;
`else
    localparam logic TLAST_EN = 1'b0;
`endif

    state_t state_q, state_d;
    logic   load, beat, final_beat, is_last;
    logic [BRAM_ADDR_WIDTH-1:0] addr;

    always_ff @(posedge aclk) begin
        if (!aresetn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        load               = 1'b0;
        s_axis_tready      = 1'b0;
        m_axis_done_tvalid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    // offset past end is a zero-length segment: report done directly
                    state_d = (cfg_offset > cfg_end) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && final_beat)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                m_axis_done_tvalid = 1'b1;
                if (m_axis_done_tready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign beat       = s_axis_tvalid & s_axis_tready;
    // With the feature disabled TLAST_EN is 0 and tlast folds away.
    assign final_beat = is_last | (TLAST_EN & s_axis_tlast);

    axis_segment_addr_cntr #(
        .ADDR_W (BRAM_ADDR_WIDTH)
    ) u_cntr (
        .clk      (aclk),
        .rst_n    (aresetn),
        .load     (load),
        .offset   (cfg_offset),
        .end_addr (cfg_end),
        .beat     (beat),
        .stop     (final_beat),
        .addr     (addr),
        .count    (sts_count),
        .is_last  (is_last)
    );

    assign sts_data        = addr;
    assign bram_portb_clk  = aclk;
    assign bram_portb_rst  = ~aresetn;
    assign bram_portb_addr = addr;
    assign bram_portb_we   = beat;

    generate
        if (BRAM_DATA_WIDTH > AXIS_TDATA_WIDTH) begin : g_zext
            assign bram_portb_wrdata = {{(BRAM_DATA_WIDTH-AXIS_TDATA_WIDTH){1'b0}}, s_axis_tdata};
        end else begin : g_trunc
            assign bram_portb_wrdata = s_axis_tdata[BRAM_DATA_WIDTH-1:0];
        end
    endgenerate

endmodule
